data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 158 +++++++++++++++
 tb/tb_data_memory.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: word-organised data RAM behind the CPU load/store port.
// Loads run through an IDLE/WAIT/RESP FSM that returns data a fixed LATENCY
// cycles after the request is first sampled. Stores complete at the edge.
// Optional feature macro: DATA_MEMORY_PERF_COUNTERS_EN adds the read_count_o
// and write_count_o event counters.

package rriscv_pkg;
    localparam int XLEN = 32;
endpackage

module data_memory
    import rriscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic            read_i,
    input  logic            write_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            rdata_valid_o,
    output logic            err_o
`ifdef DATA_MEMORY_PERF_COUNTERS_EN
    ,
    output logic [31:0]     read_count_o,
    output logic [31:0]     write_count_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [3:0]      count;
    logic [XLEN-1:0] latched_addr;
    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic            addr_legal;
    logic            conflict;
    logic            write_en;
    logic            write_err;
    logic            accept;
    logic            enter_resp;
    logic [XLEN-1:0] resp_addr;
    logic            resp_legal;
    logic [XLEN-1:0] resp_data;

    // A word access is legal when it is aligned and the word lies inside the array.
    function automatic logic is_legal(input logic [XLEN-1:0] a);
        return (a[1:0] == 2'b00) && (a[XLEN-1:IDX_W+2] == '0);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [XLEN-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    assign addr_legal = is_legal(addr_i);
    assign conflict   = (state == IDLE) && read_i && write_i;
    assign write_en   = write_i && addr_legal && !conflict && !rst_i;
    assign write_err  = write_i && !addr_legal;
    assign accept     = (state == IDLE) && read_i && !write_i;

    // The response is taken either straight from IDLE (single-cycle latency)
    // or on the last WAIT cycle while the request is still held unchanged.
    assign enter_resp = (accept && (LATENCY == 1)) ||
                        ((state == WAIT) && read_i && (addr_i == latched_addr) && (count == 4'd1));
    assign resp_addr  = (state == IDLE) ? addr_i : latched_addr;
    assign resp_legal = is_legal(resp_addr);

    // Response data; a store landing on the same edge is forwarded so the load sees it.
    always_comb begin
        resp_data = '0;
        if (resp_legal) begin
            if (write_en && (word_idx(addr_i) == word_idx(resp_addr))) begin
                resp_data = wdata_i;
            end else begin
                resp_data = mem[word_idx(resp_addr)];
            end
        end
    end

    // Storage array: legal stores outside reset, independent of the read FSM.
    always_ff @(posedge clk_i) begin
        if (write_en) begin
            mem[word_idx(addr_i)] <= wdata_i;
        end
    end

    // Read FSM with registered data, valid and error outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            count         <= '0;
            latched_addr  <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            rdata_valid_o <= enter_resp;
            err_o         <= conflict || write_err || (enter_resp && !resp_legal);
            if (enter_resp) begin
                rdata_o <= resp_data;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        latched_addr <= addr_i;
                        count        <= LAT_M1;
                        state        <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!read_i) begin
                        count <= '0;
                        state <= IDLE;
                    end else if (addr_i != latched_addr) begin
                        latched_addr <= addr_i;
                        count        <= LAT_M1;
                    end else begin
                        count <= count - 4'd1;
                        if (count == 4'd1) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DATA_MEMORY_PERF_COUNTERS_EN
    // Event counters: completed loads and performed stores, wrapping naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            read_count_o  <= '0;
            write_count_o <= '0;
        end else begin
            if (enter_resp) begin
                read_count_o <= read_count_o + 32'd1;
            end
            if (write_en) begin
                write_count_o <= write_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed scenarios plus randomized traffic on data_memory,
// checked every cycle against a transaction-level model of the memory.
// Counter checks are compiled in when DATA_MEMORY_PERF_COUNTERS_EN is defined.

module tb_data_memory;
    localparam int DEPTH = 16;
    localparam int LAT   = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] addr_i;
    logic        read_i;
    logic        write_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        err_o;
`ifdef DATA_MEMORY_PERF_COUNTERS_EN
    logic [31:0] read_count_o;
    logic [31:0] write_count_o;
`endif

    int checks   = 0;
    int failures = 0;

    data_memory #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .addr_i        (addr_i),
        .read_i        (read_i),
        .write_i       (write_i),
        .wdata_i       (wdata_i),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .err_o         (err_o)
`ifdef DATA_MEMORY_PERF_COUNTERS_EN
        ,
        .read_count_o  (read_count_o),
        .write_count_o (write_count_o)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    // Reference model: memory array plus at most one pending load with a due cycle.
    logic [31:0] mem_m [DEPTH];
    bit          started = 1'b0;
    bit          pend    = 1'b0;
    bit          resp    = 1'b0;
    logic [31:0] paddr   = '0;
    longint      cyc     = 0;
    longint      due     = 0;
    logic [31:0] exp_rdata = '0;
    bit          exp_valid = 1'b0;
    bit          exp_err   = 1'b0;
    int unsigned exp_rcount = 0;
    int unsigned exp_wcount = 0;

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a >> 2);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelStep();
        bit conf;
        bit respond;
        if (rst_i) begin
            started    = 1'b1;
            pend       = 1'b0;
            resp       = 1'b0;
            exp_valid  = 1'b0;
            exp_err    = 1'b0;
            exp_rdata  = '0;
            exp_rcount = 0;
            exp_wcount = 0;
        end else begin
            respond   = 1'b0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            conf      = !pend && !resp && read_i && write_i;
            if ((write_i && !legal(addr_i)) || conf) exp_err = 1'b1;
            if (write_i && legal(addr_i) && !conf) begin
                mem_m[widx(addr_i)] = wdata_i;
                exp_wcount++;
            end
            if (resp) begin
                resp = 1'b0;
            end else if (pend) begin
                if (!read_i) begin
                    pend = 1'b0;
                end else if (addr_i !== paddr) begin
                    paddr = addr_i;
                    due   = cyc + LAT;
                end else if (cyc + 1 == due) begin
                    respond = 1'b1;
                end
            end else if (read_i && !write_i) begin
                paddr = addr_i;
                due   = cyc + LAT;
                pend  = 1'b1;
                if (cyc + 1 == due) respond = 1'b1;
            end
            if (respond) begin
                pend      = 1'b0;
                resp      = 1'b1;
                exp_valid = 1'b1;
                exp_rcount++;
                if (legal(paddr)) begin
                    exp_rdata = mem_m[widx(paddr)];
                end else begin
                    exp_rdata = '0;
                    exp_err   = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    // Advance the model on every rising edge using the inputs the DUT samples.
    initial forever begin
        @(posedge clk_i);
        modelStep();
    end

    // Compare DUT outputs with the model in the middle of every cycle.
    initial forever begin
        @(negedge clk_i);
        if (started) begin
            checkOutput("model_valid", 32'(rdata_valid_o), 32'(exp_valid));
            checkOutput("model_err", 32'(err_o), 32'(exp_err));
            checkOutput("model_rdata", rdata_o, exp_rdata);
`ifdef DATA_MEMORY_PERF_COUNTERS_EN
            checkOutput("model_read_count", read_count_o, exp_rcount);
            checkOutput("model_write_count", write_count_o, exp_wcount);
`endif
        end
    end

    task automatic applyStimulus(input bit rs, input bit r, input bit w,
                                 input logic [31:0] a, input logic [31:0] d);
        rst_i   = rs;
        read_i  = r;
        write_i = w;
        addr_i  = a;
        wdata_i = d;
        @(negedge clk_i);
    endtask

    task automatic doRead(input logic [31:0] a, output int lat, output logic [31:0] data,
                          output logic e, output logic after);
        lat  = -1;
        data = '0;
        e    = 1'b0;
        for (int n = 0; n < 20; n++) begin
            applyStimulus(0, 1, 0, a, '0);
            if (rdata_valid_o) begin
                lat  = n + 1;
                data = rdata_o;
                e    = err_o;
                break;
            end
        end
        applyStimulus(0, 0, 0, a, '0);
        after = rdata_valid_o;
        if (lat < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL read_timeout: no rdata_valid_o for addr 0x%08h within 20 cycles, expected within %0d", a, LAT);
        end
    endtask

    function automatic logic [31:0] pickAddr();
        logic [31:0] odd [4];
        odd[0] = 32'h22;
        odd[1] = 32'h41;
        odd[2] = 32'(4 * DEPTH);
        odd[3] = 32'h8000_0000;
        if ($urandom_range(0, 99) < 85) return 32'($urandom_range(0, DEPTH - 1) * 4);
        return odd[$urandom_range(0, 3)];
    endfunction

    // Directed scenarios followed by randomized traffic.
    initial begin
        int          lat;
        logic [31:0] data;
        logic        e;
        logic        after;
        logic        seen;
        bit          rr;
        logic [31:0] ra;

        rst_i = 1'b1; read_i = 1'b0; write_i = 1'b0; addr_i = '0; wdata_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_rdata", rdata_o, 32'h0);
        checkOutput("reset_valid", 32'(rdata_valid_o), 32'h0);
        checkOutput("reset_err", 32'(err_o), 32'h0);

        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, 32'(i * 4), 32'hC0DE_0000 | 32'(i));

        applyStimulus(0, 0, 1, 32'h10, 32'hDEAD_BEEF);
        doRead(32'h10, lat, data, e, after);
        checkOutput("basic_latency", 32'(lat), 32'd2);
        checkOutput("basic_rdata", data, 32'hDEAD_BEEF);
        checkOutput("basic_err", 32'(e), 32'h0);
        checkOutput("basic_pulse_width", 32'(after), 32'h0);

        seen = 1'b0;
        applyStimulus(0, 1, 0, 32'h20, '0);
        seen |= rdata_valid_o;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 32'h20, '0);
            seen |= rdata_valid_o;
        end
        checkOutput("dropped_read_no_valid", 32'(seen), 32'h0);
        doRead(32'h24, lat, data, e, after);
        checkOutput("after_drop_latency", 32'(lat), 32'd2);
        checkOutput("after_drop_rdata", data, 32'hC0DE_0009);

        applyStimulus(0, 0, 1, 32'h20, 32'hA5A5_0020);
        doRead(32'h22, lat, data, e, after);
        checkOutput("misaligned_read_rdata", data, 32'h0);
        checkOutput("misaligned_read_err", 32'(e), 32'h1);
        doRead(32'(4 * DEPTH), lat, data, e, after);
        checkOutput("range_read_rdata", data, 32'h0);
        checkOutput("range_read_err", 32'(e), 32'h1);
        checkOutput("range_read_latency", 32'(lat), 32'd2);
        applyStimulus(0, 0, 1, 32'h22, 32'h1111_1111);
        checkOutput("illegal_write_err", 32'(err_o), 32'h1);
        applyStimulus(0, 0, 0, 32'h0, '0);
        checkOutput("err_pulse_width", 32'(err_o), 32'h0);
        doRead(32'h20, lat, data, e, after);
        checkOutput("illegal_write_no_effect", data, 32'hA5A5_0020);

        applyStimulus(0, 0, 1, 32'h30, 32'h1);
        applyStimulus(0, 1, 0, 32'h30, '0);
        applyStimulus(0, 1, 1, 32'h30, 32'h5);
        checkOutput("write_during_wait_valid", 32'(rdata_valid_o), 32'h1);
        checkOutput("write_during_wait_rdata", rdata_o, 32'h5);
        applyStimulus(0, 0, 0, 32'h0, '0);

        applyStimulus(0, 1, 1, 32'h14, 32'hBAD0_BAD0);
        checkOutput("conflict_err", 32'(err_o), 32'h1);
        seen = rdata_valid_o;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 32'h0, '0);
            seen |= rdata_valid_o;
        end
        checkOutput("conflict_no_valid", 32'(seen), 32'h0);
        doRead(32'h14, lat, data, e, after);
        checkOutput("conflict_no_write", data, 32'hC0DE_0005);

        applyStimulus(0, 1, 0, 32'h10, '0);
        applyStimulus(1, 1, 1, 32'h10, 32'h1234_5678);
        checkOutput("reset_in_wait_rdata", rdata_o, 32'h0);
        seen = rdata_valid_o;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 32'h0, '0);
            seen |= rdata_valid_o;
        end
        checkOutput("reset_in_wait_no_valid", 32'(seen), 32'h0);
        doRead(32'h10, lat, data, e, after);
        checkOutput("reset_keeps_memory", data, 32'hDEAD_BEEF);

`ifdef DATA_MEMORY_PERF_COUNTERS_EN
        applyStimulus(1, 0, 0, 32'h0, '0);
        checkOutput("counters_reset_r", read_count_o, 32'h0);
        applyStimulus(0, 0, 1, 32'h0, 32'h100);
        applyStimulus(0, 0, 1, 32'h4, 32'h104);
        applyStimulus(0, 0, 1, 32'h8, 32'h108);
        doRead(32'h0, lat, data, e, after);
        doRead(32'h4, lat, data, e, after);
        applyStimulus(0, 0, 1, 32'h41, 32'h1);
        applyStimulus(0, 0, 0, 32'h0, '0);
        checkOutput("write_count_3", write_count_o, 32'd3);
        checkOutput("read_count_2", read_count_o, 32'd2);
        applyStimulus(1, 0, 0, 32'h0, '0);
        checkOutput("write_count_cleared", write_count_o, 32'h0);
        checkOutput("read_count_cleared", read_count_o, 32'h0);
`endif

        rr = 1'b0;
        ra = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            if (!rr || $urandom_range(0, 99) < 20) ra = pickAddr();
            if ($urandom_range(0, 99) < 15) rr = !rr;
            applyStimulus($urandom_range(0, 99) < 1, rr, $urandom_range(0, 99) < 30, ra, $urandom());
            if (rdata_valid_o) rr = 1'b0;
        end
        applyStimulus(0, 0, 0, 32'h0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
